exec_wb_lane: RTL and testbench

- One execute→writeback lane of the CPU backend. The design uses four identical lanes: lane 0 handles scalar work, and lanes 1–3 join in for vector ops, each working on its own 16-bit element.
- The lane accepts a decoded instruction plus operand values from decode.
- It executes ALU, move, branch and halt ops, and produces a registered writeback request for the scalar or vector register file.
- It also produces branch-redirect and halt indications.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/lane_alu.sv | 27 ++
 rtl/exec_wb_lane.sv | 137 +++++++++++++
 tb/tb_exec_wb_lane.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU backend definitions: opcode and jump-condition encodings plus the lane data width.
package cpu_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_MOVL = 4'h4,
        OP_MOVH = 4'h5,
        OP_JMP  = 4'h6,
        OP_VADD = 4'h8,
        OP_VSUB = 4'h9,
        OP_VMUL = 4'hA,
        OP_VDIV = 4'hB,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [3:0] {
        J_Z  = 4'h0,
        J_NZ = 4'h1,
        J_S  = 4'h2,
        J_NS = 4'h3
    } jcond_e;

endpackage

// File: rtl/lane_alu.sv
// Combinational per-lane arithmetic: scalar and vector ALU ops share one datapath.
module lane_alu #(
    parameter int WIDTH = cpu_pkg::WIDTH
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] x,
    input  logic [7:0]       imm8,
    output logic [WIDTH-1:0] y
);
    import cpu_pkg::*;

    always_comb begin
        y = '0;
        case (op)
            OP_ADD, OP_VADD: y = a + x;
            OP_SUB, OP_VSUB: y = a - x;
            OP_MUL, OP_VMUL: y = a * x;
            // Divide by zero saturates to all ones instead of being undefined.
            OP_DIV, OP_VDIV: y = (x == '0) ? '1 : a / x;
            OP_MOVL:         y = {{(WIDTH-8){imm8[7]}}, imm8};
            OP_MOVH:         y = WIDTH'({imm8, x[7:0]});
            default:         y = '0;
        endcase
    end

endmodule

// File: rtl/exec_wb_lane.sv
// One execute/writeback lane: X input register, combinational ALU, registered WB request,
// plus branch redirect and sticky halt (lane 0 only).
module exec_wb_lane #(
    parameter int WIDTH = cpu_pkg::WIDTH,
    parameter int LANE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [15:0]      in_ins,
    input  logic [15:0]      in_pc,
    input  logic [WIDTH-1:0] in_ra_val,
    input  logic [WIDTH-1:0] in_rx_val,
    input  logic             stall,
    input  logic             flush,
    output logic             x_branch_taken,
    output logic [15:0]      x_branch_target,
    output logic             wb_wen,
    output logic             wb_vwen,
    output logic [3:0]       wb_waddr,
    output logic [WIDTH-1:0] wb_wdata,
    output logic             halted
);
    import cpu_pkg::*;

    localparam logic IS_LANE0 = (LANE == 0);

    logic             x_valid;
    logic [15:0]      x_ins;
    logic [WIDTH-1:0] x_ra;
    logic [WIDTH-1:0] x_rx;

    logic [3:0]       x_op;
    logic [3:0]       x_sub;
    logic             x_live;
    logic             scalar_wr;
    logic             vector_wr;
    logic             jump;
    logic             halt_op;
    logic             cond;
    logic             halting;
    logic             write_go;
    logic [WIDTH-1:0] alu_y;
    logic             unused_ok;

    assign unused_ok = ^in_pc;

    assign x_op  = x_ins[15:12];
    assign x_sub = x_ins[7:4];

    // A flushed instruction is dead for the whole cycle: no branch, no halt, no write.
    assign x_live = x_valid && !flush;

    always_comb begin
        scalar_wr = 1'b0;
        vector_wr = 1'b0;
        jump      = 1'b0;
        halt_op   = 1'b0;
        case (x_op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOVL, OP_MOVH: scalar_wr = IS_LANE0;
            OP_VADD, OP_VSUB, OP_VMUL, OP_VDIV:               vector_wr = 1'b1;
            OP_JMP:                                           jump      = IS_LANE0;
            OP_HALT:                                          halt_op   = IS_LANE0;
            default: ;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (x_sub)
            J_Z:     cond = (x_ra == '0);
            J_NZ:    cond = (x_ra != '0);
            J_S:     cond = x_ra[WIDTH-1];
            J_NS:    cond = !x_ra[WIDTH-1];
            default: cond = 1'b0;
        endcase
    end

    assign x_branch_taken  = x_live && jump && cond;
    assign x_branch_target = x_rx[15:0];

    assign halting  = x_live && halt_op;
    assign write_go = x_live && !stall;

    lane_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .op  (x_op),
        .a   (x_ra),
        .x   (x_rx),
        .imm8(x_ins[11:4]),
        .y   (alu_y)
    );

    // The halt consumes its own X slot, so the instruction behind it is never captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_valid <= 1'b0;
            x_ins   <= '0;
            x_ra    <= '0;
            x_rx    <= '0;
            halted  <= 1'b0;
        end else begin
            if (halting) begin
                halted <= 1'b1;
            end
            if (flush || halting) begin
                x_valid <= 1'b0;
            end else if (!stall && !halted) begin
                x_valid <= in_valid;
                x_ins   <= in_ins;
                x_ra    <= in_ra_val;
                x_rx    <= in_rx_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_wen   <= 1'b0;
            wb_vwen  <= 1'b0;
            wb_waddr <= '0;
            wb_wdata <= '0;
        end else if (write_go && (scalar_wr || vector_wr)) begin
            wb_wen   <= scalar_wr;
            wb_vwen  <= vector_wr;
            wb_waddr <= x_ins[3:0];
            wb_wdata <= alu_y;
        end else begin
            wb_wen   <= 1'b0;
            wb_vwen  <= 1'b0;
            wb_waddr <= '0;
            wb_wdata <= '0;
        end
    end

endmodule

// File: tb/tb_exec_wb_lane.sv
// Directed bench for exec_wb_lane: lane 0 and lane 2 instances share one input stream.
module tb_exec_wb_lane;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_ins;
    logic [15:0] in_pc;
    logic [15:0] in_ra_val;
    logic [15:0] in_rx_val;
    logic        stall;
    logic        flush;

    logic        taken0, taken2;
    logic [15:0] target0, target2;
    logic        wen0, wen2, vwen0, vwen2;
    logic [3:0]  waddr0, waddr2;
    logic [15:0] wdata0, wdata2;
    logic        halted0, halted2;

    int checks = 0;
    int errors = 0;

    exec_wb_lane #(.WIDTH(16), .LANE(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ins(in_ins), .in_pc(in_pc),
        .in_ra_val(in_ra_val), .in_rx_val(in_rx_val), .stall(stall), .flush(flush),
        .x_branch_taken(taken0), .x_branch_target(target0), .wb_wen(wen0), .wb_vwen(vwen0),
        .wb_waddr(waddr0), .wb_wdata(wdata0), .halted(halted0)
    );

    exec_wb_lane #(.WIDTH(16), .LANE(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ins(in_ins), .in_pc(in_pc),
        .in_ra_val(in_ra_val), .in_rx_val(in_rx_val), .stall(stall), .flush(flush),
        .x_branch_taken(taken2), .x_branch_target(target2), .wb_wen(wen2), .wb_vwen(vwen2),
        .wb_waddr(waddr2), .wb_wdata(wdata2), .halted(halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] ra,
                         input logic [15:0] rx);
        in_valid  = v;
        in_ins    = ins;
        in_ra_val = ra;
        in_rx_val = rx;
        in_pc     = in_pc + 16'd2;
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Present one instruction, then idle; returns at the negedge after its WB edge.
    task automatic run_op(input logic [15:0] ins, input logic [15:0] ra, input logic [15:0] rx);
        drive(1'b1, ins, ra, rx);
        tick();
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
        tick();
    endtask

    task automatic check_wb0(input string tag, input logic wen, input logic vwen,
                             input logic [3:0] addr, input logic [15:0] data);
        check({tag, ".wen0"},   {31'd0, wen0},  {31'd0, wen});
        check({tag, ".vwen0"},  {31'd0, vwen0}, {31'd0, vwen});
        check({tag, ".waddr0"}, {28'd0, waddr0}, {28'd0, addr});
        check({tag, ".wdata0"}, {16'd0, wdata0}, {16'd0, data});
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        in_pc = 16'h0000;
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
        tick();
        tick();
        check_wb0("reset", 1'b0, 1'b0, 4'd0, 16'h0000);
        check("reset.halted0", {31'd0, halted0}, 32'd0);
        check("reset.taken0",  {31'd0, taken0},  32'd0);
        reset = 1'b0;
        tick();

        run_op(16'h0003, 16'd5, 16'd7);
        check_wb0("add", 1'b1, 1'b0, 4'd3, 16'd12);
        check("add.lane2_wen",  {31'd0, wen2},  32'd0);
        check("add.lane2_vwen", {31'd0, vwen2}, 32'd0);
        tick();
        check("add.next_bubble", {31'd0, wen0}, 32'd0);

        run_op(16'h3001, 16'd100, 16'd0);
        check_wb0("div0", 1'b1, 1'b0, 4'd1, 16'hFFFF);
        run_op(16'h3007, 16'd100, 16'd7);
        check_wb0("div", 1'b1, 1'b0, 4'd7, 16'd14);
        run_op(16'h4802, 16'h0000, 16'h0000);
        check_wb0("movl", 1'b1, 1'b0, 4'd2, 16'hFF80);
        run_op(16'h5124, 16'h0000, 16'h34AB);
        check_wb0("movh", 1'b1, 1'b0, 4'd4, 16'h12AB);
        run_op(16'h1005, 16'd0, 16'd1);
        check_wb0("sub", 1'b1, 1'b0, 4'd5, 16'hFFFF);
        run_op(16'h2006, 16'd300, 16'd300);
        check_wb0("mul", 1'b1, 1'b0, 4'd6, 16'h5F90);
        run_op(16'hC001, 16'd3, 16'd4);
        check_wb0("memop", 1'b0, 1'b0, 4'd0, 16'h0000);

        run_op(16'hA00B, 16'd3, 16'd4);
        check_wb0("vmul", 1'b0, 1'b1, 4'hB, 16'd12);
        check("vmul.lane2_vwen",  {31'd0, vwen2}, 32'd1);
        check("vmul.lane2_wen",   {31'd0, wen2},  32'd0);
        check("vmul.lane2_waddr", {28'd0, waddr2}, 32'hB);
        check("vmul.lane2_wdata", {16'd0, wdata2}, 32'd12);

        // Jumps: taken visible in the cycle after the accepting edge.
        drive(1'b1, 16'h6000, 16'h0000, 16'h0040);
        tick();
        check("jz.taken",  {31'd0, taken0}, 32'd1);
        check("jz.target", {16'd0, target0}, 32'h0040);
        check("jz.lane2",  {31'd0, taken2}, 32'd0);
        drive(1'b1, 16'h6000, 16'h0001, 16'h0040);
        tick();
        check("jz.not_taken", {31'd0, taken0}, 32'd0);
        check("jz.no_write",  {31'd0, wen0},   32'd0);
        drive(1'b1, 16'h6020, 16'h8000, 16'h0123);
        tick();
        check("js.taken",  {31'd0, taken0}, 32'd1);
        check("js.target", {16'd0, target0}, 32'h0123);
        drive(1'b1, 16'h6030, 16'h8000, 16'h0123);
        tick();
        check("jns.not_taken", {31'd0, taken0}, 32'd0);
        drive(1'b1, 16'h6010, 16'h0002, 16'h0077);
        tick();
        check("jnz.taken", {31'd0, taken0}, 32'd1);
        drive(1'b1, 16'h6050, 16'h0000, 16'h0077);
        tick();
        check("jbad.not_taken", {31'd0, taken0}, 32'd0);
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
        tick();
        check("jmp.cleared", {31'd0, taken0}, 32'd0);
        check("jmp.no_write", {31'd0, wen0 | vwen0}, 32'd0);

        // Stall two cycles with an add in X; the stalled-cycle input must be ignored.
        drive(1'b1, 16'h0004, 16'd2, 16'd3);
        tick();
        stall = 1'b1;
        drive(1'b1, 16'h0005, 16'd9, 16'd9);
        tick();
        check("stall.bubble1", {31'd0, wen0}, 32'd0);
        tick();
        check("stall.bubble2", {31'd0, wen0}, 32'd0);
        stall = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
        tick();
        check_wb0("stall.release", 1'b1, 1'b0, 4'd4, 16'd5);
        tick();
        check("stall.dropped", {31'd0, wen0}, 32'd0);

        // Flush with a jump in X.
        drive(1'b1, 16'h6000, 16'h0000, 16'h0050);
        tick();
        flush = 1'b1;
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
        #1;
        check("flush.no_branch", {31'd0, taken0}, 32'd0);
        tick();
        flush = 1'b0;
        check("flush.no_write", {31'd0, wen0}, 32'd0);
        check("flush.x_clear",  {31'd0, taken0}, 32'd0);

        // Flush and stall together clear X.
        drive(1'b1, 16'h0006, 16'd1, 16'd1);
        tick();
        stall = 1'b1;
        flush = 1'b1;
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
        tick();
        stall = 1'b0;
        flush = 1'b0;
        check("flstall.bubble", {31'd0, wen0}, 32'd0);
        tick();
        check("flstall.killed", {31'd0, wen0}, 32'd0);

        // Flush does not touch an instruction already in WB.
        run_op(16'h0007, 16'd3, 16'd4);
        flush = 1'b1;
        #1;
        check_wb0("flush_wb", 1'b1, 1'b0, 4'd7, 16'd7);
        tick();
        flush = 1'b0;

        // Halt followed by an add.
        drive(1'b1, 16'hF000, 16'h0000, 16'h0000);
        tick();
        drive(1'b1, 16'h0008, 16'd1, 16'd1);
        check("halt.not_yet", {31'd0, halted0}, 32'd0);
        tick();
        check("halt.set", {31'd0, halted0}, 32'd1);
        check("halt.lane2", {31'd0, halted2}, 32'd0);
        tick();
        check("halt.no_write1", {31'd0, wen0}, 32'd0);
        tick();
        check("halt.no_write2", {31'd0, wen0}, 32'd0);
        check("halt.sticky", {31'd0, halted0}, 32'd1);
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("halt.reset", {31'd0, halted0}, 32'd0);
        run_op(16'h0009, 16'd2, 16'd2);
        check_wb0("post_halt", 1'b1, 1'b0, 4'd9, 16'd4);

        // Reset mid-flight discards the instruction in X.
        drive(1'b1, 16'h000A, 16'd5, 16'd5);
        tick();
        reset = 1'b1;
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
        tick();
        reset = 1'b0;
        check("midreset.no_write", {31'd0, wen0}, 32'd0);
        tick();
        check("midreset.still_none", {31'd0, wen0}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
